// File: rtl/tx_fifo_arb.sv
// Round-robin, frame-atomic arbiter feeding the TX FIFO write port from NUM_CH framers.
// Optional per-frame header beat (granted channel index) enabled by `define TX_FIFO_ARB_HDR_EN.
module tx_fifo_arb #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH-1:0]            i_last,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_ready,
    input  logic                         i_afull,
    output logic                         o_push,
    output logic [DATA_WIDTH-1:0]        o_wdata,
    output logic [NUM_CH-1:0]            o_grant,
    output logic [CNT_WIDTH-1:0]         o_frames
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef TX_FIFO_ARB_HDR_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

    state_t                state, state_nx;
    logic [IDX_W-1:0]      grant_idx, idx_nx;
    logic [IDX_W-1:0]      ptr, ptr_nx;
    logic [NUM_CH-1:0]     grant_nx;
    logic                  push_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic [CNT_WIDTH-1:0]  frames_nx;
    logic                  pick_vld;
    logic [IDX_W-1:0]      pick_idx;
    logic [DATA_WIDTH-1:0] beat;
    logic                  accept;

    // (base + off) mod NUM_CH without a divider
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return IDX_W'(s);
    endfunction

    // First requesting channel at or above the pointer, wrapping
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!pick_vld && i_valid[rr_idx(ptr, i)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_idx(ptr, i);
            end
        end
    end

    always_comb begin
        beat = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant_idx == IDX_W'(k)) beat = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign o_ready = (state == S_XFER && !i_afull) ? o_grant : '0;
    assign accept  = (state == S_XFER) && i_valid[grant_idx] && !i_afull;

    always_comb begin
        state_nx  = state;
        grant_nx  = o_grant;
        idx_nx    = grant_idx;
        ptr_nx    = ptr;
        push_nx   = 1'b0;
        wdata_nx  = o_wdata;
        frames_nx = o_frames;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_nx = NUM_CH'(1) << pick_idx;
                    idx_nx   = pick_idx;
`ifdef TX_FIFO_ARB_HDR_EN
                    state_nx = S_HDR;
`else
                    state_nx = S_XFER;
`endif
                end
            end
`ifdef TX_FIFO_ARB_HDR_EN
            S_HDR: begin
                if (!i_afull) begin
                    push_nx  = 1'b1;
                    wdata_nx = DATA_WIDTH'(grant_idx);
                    state_nx = S_XFER;
                end
            end
`endif
            S_XFER: begin
                if (accept) begin
                    push_nx  = 1'b1;
                    wdata_nx = beat;
                    // Frame done: release the grant and rotate priority past it
                    if (i_last[grant_idx]) begin
                        state_nx  = S_IDLE;
                        grant_nx  = '0;
                        ptr_nx    = rr_idx(grant_idx, 1);
                        frames_nx = o_frames + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            grant_idx <= '0;
            ptr       <= '0;
            o_grant   <= '0;
            o_push    <= 1'b0;
            o_wdata   <= '0;
            o_frames  <= '0;
        end else begin
            state     <= state_nx;
            grant_idx <= idx_nx;
            ptr       <= ptr_nx;
            o_grant   <= grant_nx;
            o_push    <= push_nx;
            o_wdata   <= wdata_nx;
            o_frames  <= frames_nx;
        end
    end

endmodule

// File: doc/tx_fifo_arb.md
Name: tx_fifo_arb

Overview:
- Round-robin arbiter that shares the push side of the TX FIFO between NUM_CH frame-based source channels.
- Grants one channel at a time and holds the grant until that channel's last beat, so frames never interleave.
- Forwards beats as registered push/data to the FIFO write port, and stalls all sources while the FIFO reports almost-full.
- Sits in the FIFO write-clock domain, between the channel framers and the FIFO.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_WIDTH, 8, beat width; equals the FIFO data width.
- CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- i_clk  input  1  FIFO write clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  NUM_CH  per-channel beat valid.
- i_last  input  NUM_CH  per-channel last beat of frame; qualified by i_valid.
- i_data  input  NUM_CH*DATA_WIDTH  per-channel beat data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_ready  output  NUM_CH  per-channel beat accept.
- i_afull  input  1  FIFO almost-full.
- o_push  output  1  FIFO push strobe (registered).
- o_wdata  output  DATA_WIDTH  FIFO write data (registered).
- o_grant  output  NUM_CH  one-hot current grant; all zero when idle.
- o_frames  output  CNT_WIDTH  completed frames counter; wraps.

Behaviour:
- Reset values:
  - o_push=0, o_wdata=0, o_grant=0, o_frames=0.
  - State=IDLE, round-robin pointer=0.
  - o_ready is combinational and therefore 0 whenever State=IDLE.
- States: IDLE, HDR (only when the optional feature is enabled), XFER.
- IDLE:
  - If any i_valid is set, pick the first set channel searching upward from the pointer, modulo NUM_CH.
  - Register the one-hot winner into o_grant.
  - Next state is XFER, or HDR when the feature is enabled.
  - No beat is accepted in IDLE.
- XFER:
  - o_ready[g] = ~i_afull for the granted channel g; all other o_ready bits are 0.
  - A beat is accepted when i_valid[g] & o_ready[g].
  - On an accepted beat, the next cycle has o_push=1 and o_wdata=that beat (1-cycle latency). Otherwise o_push=0 and o_wdata holds its previous value.
- On an accepted beat with i_last[g]=1:
  - State goes to IDLE and o_grant clears.
  - Pointer is set to (g+1) mod NUM_CH.
  - o_frames increments, wrapping at 2^CNT_WIDTH.
  - Result: at least 1 idle cycle between frames, and a channel requesting continuously cannot starve the others.
- i_afull:
  - Sampled combinationally.
  - While it is high, no beat is accepted and no push is issued.
  - The FIFO afull threshold must leave at least 1 entry of slack for the registered push already in flight.
- Invalid input handling:
  - A source dropping i_valid mid-frame only stalls the frame; the grant is held indefinitely.
  - i_valid/i_last/i_data of non-granted channels are ignored.
- Pointer wraps NUM_CH-1 -> 0.
- A single requester is granted back-to-back frames, with 1 idle cycle between them.
- i_rst asserted mid-frame:
  - All state returns to reset values on the next edge; the in-flight push is dropped.
  - Beats already pushed into the FIFO stay there (no retraction).
  - Upstream frame resynchronisation is the sources' responsibility.

Optional Feature:
- Macro: TX_FIFO_ARB_HDR_EN.
- Defined:
  - After a grant, State=HDR. While ~i_afull, push one header beat = granted channel index, zero-extended to DATA_WIDTH, then go to XFER.
  - o_ready is 0 in HDR.
  - Requires DATA_WIDTH >= clog2(NUM_CH).
- Undefined:
  - The HDR state and its logic are absent; IDLE goes straight to XFER.
  - The FIFO stream carries payload only.

Test Plan:
- Single frame: ch2 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), i_afull=0.
  - o_grant=4'b0100 one cycle after valid; 3 consecutive o_push with matching data.
  - o_frames=1; o_grant returns to 0.
- Round-robin fairness: all 4 channels continuously send 2-beat frames.
  - Grant order is ch0,ch1,ch2,ch3,ch0.
  - No interleaving; o_frames=5 after 5 frames.
- Backpressure: i_afull=1 for 4 cycles in the middle of a 5-beat ch1 frame.
  - o_ready[1]=0 and no o_push during the stall; all 5 beats are delivered in order, none dropped or duplicated.
- Reset mid-frame: assert i_rst after beat 2 of a 4-beat ch3 frame.
  - Next cycle all outputs equal their reset values.
  - A new ch0 frame is then granted with the pointer at 0.
- Counter wrap: with CNT_WIDTH=4, send 17 single-beat frames.
  - o_frames reads 1.
- With TX_FIFO_ARB_HDR_EN: ch3 frame of 0x55,0x66.
  - Pushed stream is 0x03,0x55,0x66.
  - o_ready[3]=0 during the header cycle.
